// File: rtl/serial_twos_comp.sv
// Serial LSB-first two's complement unit: pass, negate or absolute value.
// Words are collected serially, held, then re-emitted with a 1-cycle latency.
module serial_twos_comp #(
  parameter int WIDTH = 8
) (
  input  logic       t_clk,
  input  logic       r,
  input  logic       i,
  input  logic       i_valid,
  input  logic [1:0] mode,
  output logic       y,
  output logic       y_valid,
  output logic       y_last,
  output logic       ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [CW-1:0]    in_cnt;
  logic [WIDTH-1:0] in_reg;
  logic [WIDTH-1:0] hold_word;
  logic [1:0]       hold_mode;
  logic             capture;

  state_t           state, state_nx;
  logic [CW-1:0]    out_idx, out_idx_nx;
  logic             seen_one, seen_one_nx;
  logic             neg;
  logic             cur_bit;
  logic             is_last;

  assign capture = i_valid && (in_cnt == LAST);

  always_ff @(posedge t_clk) begin
    if (r) begin
      in_cnt    <= '0;
      in_reg    <= '0;
      hold_word <= '0;
      hold_mode <= 2'b00;
    end else if (i_valid) begin
      in_reg[in_cnt] <= i;
      in_cnt         <= capture ? '0 : in_cnt + CW'(1);
      if (capture) begin
        hold_word <= {i, in_reg[WIDTH-2:0]};
        hold_mode <= mode;
      end
    end
  end

  // Reserved mode 11 falls through to pass.
  always_comb begin
    neg = 1'b0;
    unique case (1'b1)
      (hold_mode == 2'b01): neg = 1'b1;
      (hold_mode == 2'b10): neg = hold_word[WIDTH-1];
      default:              neg = 1'b0;
    endcase
  end

  assign cur_bit = hold_word[out_idx];
  assign is_last = (out_idx == LAST);

  always_ff @(posedge t_clk) begin
    if (r) begin
      state    <= IDLE;
      out_idx  <= '0;
      seen_one <= 1'b0;
    end else begin
      state    <= state_nx;
      out_idx  <= out_idx_nx;
      seen_one <= seen_one_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    out_idx_nx  = out_idx;
    seen_one_nx = seen_one;
    y           = 1'b0;
    y_valid     = 1'b0;
    y_last      = 1'b0;
    ovf         = 1'b0;
    unique case (state)
      IDLE: ;
      SHIFT: begin
        y           = cur_bit ^ (neg & seen_one);
        y_valid     = 1'b1;
        y_last      = is_last;
        ovf         = is_last && neg && (hold_word == MOST_NEG);
        seen_one_nx = seen_one | cur_bit;
        out_idx_nx  = out_idx + CW'(1);
        if (is_last) begin
          state_nx   = IDLE;
          out_idx_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A fresh capture restarts the engine with no gap.
    if (capture) begin
      state_nx    = SHIFT;
      out_idx_nx  = '0;
      seen_one_nx = 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_twos_comp.sv
// Directed bench for serial_twos_comp at WIDTH=8.
// Expected words are hand-computed two's complement results.
module tb_serial_twos_comp;

  logic       t_clk;
  logic       r;
  logic       i;
  logic       i_valid;
  logic [1:0] mode;
  logic       y;
  logic       y_valid;
  logic       y_last;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  serial_twos_comp #(.WIDTH(8)) dut (
    .t_clk   (t_clk),
    .r       (r),
    .i       (i),
    .i_valid (i_valid),
    .mode    (mode),
    .y       (y),
    .y_valid (y_valid),
    .y_last  (y_last),
    .ovf     (ovf)
  );

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  task automatic tick(input logic b, input logic v, input logic [1:0] m);
    i       = b;
    i_valid = v;
    mode    = m;
    @(posedge t_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_word(input logic [7:0] w, input logic [1:0] m,
                          input bit gaps, output logic [7:0] res,
                          output bit early, output bit shape_ok,
                          output logic ovf_last);
    early    = 1'b0;
    shape_ok = 1'b1;
    ovf_last = 1'b0;
    res      = '0;
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tick(1'b0, 1'b0, m);
          if (y_valid) early = 1'b1;
        end
      end
      tick(w[k], 1'b1, m);
      if (k < 7 && y_valid) early = 1'b1;
    end
    for (int j = 0; j < 8; j++) begin
      if (j > 0) tick(1'b0, 1'b0, m);
      res[j] = y;
      if (y_valid !== 1'b1) shape_ok = 1'b0;
      if (y_last !== (j == 7)) shape_ok = 1'b0;
      if (j < 7 && ovf !== 1'b0) shape_ok = 1'b0;
      if (j == 7) ovf_last = ovf;
    end
    tick(1'b0, 1'b0, m);
    if (y_valid || y || y_last || ovf) shape_ok = 1'b0;
  endtask

  logic [7:0]  res;
  logic [15:0] res16;
  logic        ovf_last;
  bit          early;
  bit          shape_ok;
  int          vcnt;
  logic [15:0] lasts;

  initial begin
    r       = 1'b1;
    i       = 1'b0;
    i_valid = 1'b0;
    mode    = 2'b00;
    tick(1'b0, 1'b0, 2'b00);
    tick(1'b0, 1'b0, 2'b00);
    check("reset_outputs", {28'd0, y, y_valid, y_last, ovf}, 32'h0);
    r = 1'b0;
    tick(1'b0, 1'b0, 2'b00);
    check("idle_outputs", {28'd0, y, y_valid, y_last, ovf}, 32'h0);

    run_word(8'h05, 2'b01, 1'b0, res, early, shape_ok, ovf_last);
    check("neg_05_result", {24'd0, res}, 32'hFB);
    check("neg_05_shape", {31'd0, shape_ok}, 32'h1);
    check("neg_05_no_early", {31'd0, early}, 32'h0);
    check("neg_05_ovf", {31'd0, ovf_last}, 32'h0);

    run_word(8'hFB, 2'b10, 1'b0, res, early, shape_ok, ovf_last);
    check("abs_FB_result", {24'd0, res}, 32'h05);
    run_word(8'h05, 2'b10, 1'b0, res, early, shape_ok, ovf_last);
    check("abs_05_result", {24'd0, res}, 32'h05);

    run_word(8'h80, 2'b01, 1'b0, res, early, shape_ok, ovf_last);
    check("neg_80_result", {24'd0, res}, 32'h80);
    check("neg_80_ovf", {31'd0, ovf_last}, 32'h1);
    check("neg_80_shape", {31'd0, shape_ok}, 32'h1);
    run_word(8'h80, 2'b00, 1'b0, res, early, shape_ok, ovf_last);
    check("pass_80_result", {24'd0, res}, 32'h80);
    check("pass_80_ovf", {31'd0, ovf_last}, 32'h0);

    run_word(8'h05, 2'b11, 1'b0, res, early, shape_ok, ovf_last);
    check("rsvd_05_result", {24'd0, res}, 32'h05);
    run_word(8'hA6, 2'b01, 1'b0, res, early, shape_ok, ovf_last);
    check("neg_A6_result", {24'd0, res}, 32'h5A);

    run_word(8'h05, 2'b01, 1'b1, res, early, shape_ok, ovf_last);
    check("gap_05_result", {24'd0, res}, 32'hFB);
    check("gap_05_latency", {30'd0, early, shape_ok}, 32'h1);

    // Back-to-back words: 0x01 then 0x7F, negated, i_valid held high.
    res16 = '0;
    vcnt  = 0;
    lasts = '0;
    for (int t = 0; t < 23; t++) begin
      if (t < 8)       tick(t == 0, 1'b1, 2'b01);
      else if (t < 16) tick(1'b1 ^ (t == 15), 1'b1, 2'b01);
      else             tick(1'b0, 1'b0, 2'b01);
      if (t >= 7) begin
        res16[t-7] = y;
        lasts[t-7] = y_last;
        if (y_valid) vcnt++;
      end
    end
    check("b2b_result", {16'd0, res16}, 32'h81FF);
    check("b2b_valid_count", vcnt, 32'd16);
    check("b2b_last_pos", {16'd0, lasts}, 32'h8080);
    tick(1'b0, 1'b0, 2'b00);
    check("b2b_idle", {31'd0, y_valid}, 32'h0);

    // Partial word discarded by reset; reset wins over i_valid.
    tick(1'b1, 1'b1, 2'b01);
    tick(1'b1, 1'b1, 2'b01);
    tick(1'b1, 1'b1, 2'b01);
    r = 1'b1;
    tick(1'b1, 1'b1, 2'b01);
    check("rst_mid_outputs", {28'd0, y, y_valid, y_last, ovf}, 32'h0);
    r = 1'b0;
    run_word(8'h03, 2'b00, 1'b0, res, early, shape_ok, ovf_last);
    check("rst_03_result", {24'd0, res}, 32'h03);
    check("rst_03_shape", {30'd0, early, shape_ok}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
